// File: rtl/eval_pkg.sv
// eval_pkg: shared constants, square mirroring helper and FSM state type for the eval pipeline.
`default_nettype none

package eval_pkg;

  localparam int NUM_SQ  = 64;
  localparam int ENTRY_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } kpst_state_t;

  // Rank mirror: flips rank (bits 5:3) and keeps file, so black reads the white-oriented map.
  function automatic logic [5:0] mirror_sq(input logic [5:0] sq);
    return sq ^ 6'd56;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kpst_lane.sv
// kpst_lane: one scan lane; selects the (optionally mirrored) map entry for a square and
// returns it sign-extended to SCORE_W when the square is occupied, else zero.
`default_nettype none

module kpst_lane #(
  parameter int ENTRY_W = eval_pkg::ENTRY_W,
  parameter int SCORE_W = 12
) (
  input  logic [5:0]                            sq,
  input  logic                                  side,
  input  logic                                  occ,
  input  logic [eval_pkg::NUM_SQ*ENTRY_W-1:0]   map_in,
  output logic [SCORE_W-1:0]                    contrib
);
  import eval_pkg::*;

  logic [5:0]                map_sq;
  logic signed [ENTRY_W-1:0] entry;

  always_comb begin
    map_sq  = side ? mirror_sq(sq) : sq;
    entry   = map_in[map_sq*ENTRY_W +: ENTRY_W];
    contrib = occ ? SCORE_W'(entry) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/king_pst_accumulator.sv
// king_pst_accumulator: walks a king bitboard and sums signed piece-square entries.
// Optional KPST_EARLY_EXIT_EN: stop scanning once no occupied squares remain.
`default_nettype none

module king_pst_accumulator #(
  parameter int ENTRY_W    = eval_pkg::ENTRY_W,
  parameter int SQ_PER_CYC = 1,
  parameter int SCORE_W    = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                side,
  input  logic [63:0]                         bitboard,
  input  logic [eval_pkg::NUM_SQ*ENTRY_W-1:0] map_in,
  output logic                                busy,
  output logic                                done,
  output logic [SCORE_W-1:0]                  score
);
  import eval_pkg::*;

  kpst_state_t        state, state_nxt;
  logic [5:0]         index;
  logic [63:0]        bb_q;
  logic               side_q;
  logic [SCORE_W-1:0] acc, acc_nxt, lane_sum;
  logic               last_group;
  logic [5:0]         lane_sq  [SQ_PER_CYC];
  logic [SCORE_W-1:0] contrib  [SQ_PER_CYC];

  for (genvar k = 0; k < SQ_PER_CYC; k++) begin : g_lane
    assign lane_sq[k] = index + 6'(k);
    kpst_lane #(
      .ENTRY_W (ENTRY_W),
      .SCORE_W (SCORE_W)
    ) u_lane (
      .sq      (lane_sq[k]),
      .side    (side_q),
      .occ     (bb_q[lane_sq[k]]),
      .map_in  (map_in),
      .contrib (contrib[k])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < SQ_PER_CYC; k++) begin
      lane_sum = lane_sum + contrib[k];
    end
    acc_nxt = acc + lane_sum;
  end

`ifdef KPST_EARLY_EXIT_EN
  logic [63:0] grp_mask, bb_rem;
  assign grp_mask   = {{(64-SQ_PER_CYC){1'b0}}, {SQ_PER_CYC{1'b1}}};
  assign bb_rem     = bb_q & ~(grp_mask << index);
  assign last_group = (bb_rem == 64'd0);
`else
  assign last_group = (index == 6'(NUM_SQ - SQ_PER_CYC));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_group) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  // Score is captured on the final SCAN edge so it is already valid during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      index  <= '0;
      acc    <= '0;
      score  <= '0;
      bb_q   <= '0;
      side_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            bb_q   <= bitboard;
            side_q <= side;
            acc    <= '0;
            index  <= '0;
          end
        end
        SCAN: begin
          acc   <= acc_nxt;
          index <= index + 6'(SQ_PER_CYC);
`ifdef KPST_EARLY_EXIT_EN
          bb_q  <= bb_rem;
`endif
          if (last_group) score <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
